product_accumulator: RTL and testbench

//  Downstream consumer of the 16x16 array multiplier's 32-bit product.

---
 rtl/mult_pkg.sv | 12 +
 rtl/acc_adder.sv | 13 +
 rtl/product_accumulator.sv | 108 ++++++++++
 tb/tb_product_accumulator.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared definitions for the multiplier datapath and its downstream accumulator.
package mult_pkg;

  localparam int PROD_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    HOLD
  } acc_state_t;

endpackage

// File: rtl/acc_adder.sv
// Combinational accumulator adder: sum of the running total and a zero-extended product, with carry out.
module acc_adder #(
  parameter int ACC_W = 40
) (
  input  logic [ACC_W-1:0] acc,
  input  logic [ACC_W-1:0] prod,
  output logic [ACC_W-1:0] sum,
  output logic             cout
);

  assign {cout, sum} = {1'b0, acc} + {1'b0, prod};

endmodule

// File: rtl/product_accumulator.sv
// Accumulates a stream of unsigned products into groups closed by 'last' or MAX_TERMS,
// then presents the group sum on a valid/ready result interface.
module product_accumulator
  import mult_pkg::*;
#(
  parameter  int PROD_W    = mult_pkg::PROD_W,
  parameter  int ACC_W     = 40,
  parameter  int MAX_TERMS = 256,
  localparam int CNT_W     = $clog2(MAX_TERMS + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              prod_valid,
  input  logic [PROD_W-1:0] prod_data,
  input  logic              prod_last,
  output logic              prod_ready,
  output logic              acc_valid,
  output logic [ACC_W-1:0]  acc_data,
  output logic [CNT_W-1:0]  acc_count,
  output logic              acc_ovf,
  input  logic              out_ready
);

  acc_state_t       state_q, state_d;
  logic [ACC_W-1:0] acc_q;
  logic [CNT_W-1:0] cnt_q;
  logic             ovf_q;

  logic [ACC_W-1:0] prod_ext;
  logic [ACC_W-1:0] sum;
  logic             cout;
  logic [CNT_W-1:0] cnt_inc;
  logic             accept;
  logic             load_first;
  logic             add_term;
  logic             clear;

  assign prod_ext = {{(ACC_W - PROD_W){1'b0}}, prod_data};
  assign cnt_inc  = cnt_q + CNT_W'(1);

  // Ready comes from registered state only, so upstream never sees a combinational path.
  assign prod_ready = (state_q != HOLD);
  assign accept     = prod_valid & prod_ready;

  acc_adder #(.ACC_W(ACC_W)) u_adder (
    .acc  (acc_q),
    .prod (prod_ext),
    .sum  (sum),
    .cout (cout)
  );

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves a latch behind.
    state_d    = state_q;
    load_first = 1'b0;
    add_term   = 1'b0;
    clear      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          load_first = 1'b1;
          state_d    = (prod_last || MAX_TERMS == 1) ? HOLD : ACCUM;
        end
      end
      ACCUM: begin
        if (accept) begin
          add_term = 1'b1;
          if (prod_last || cnt_inc == CNT_W'(MAX_TERMS)) state_d = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          clear   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      acc_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else if (load_first) begin
      acc_q <= prod_ext;
      cnt_q <= CNT_W'(1);
      ovf_q <= 1'b0;
    end else if (add_term) begin
      acc_q <= sum;
      cnt_q <= cnt_inc;
      ovf_q <= ovf_q | cout;
    end
  end

  assign acc_valid = (state_q == HOLD);
  assign acc_data  = acc_q;
  assign acc_count = cnt_q;
  assign acc_ovf   = ovf_q;

endmodule

// File: tb/tb_product_accumulator.sv
// Self-checking bench: a group-level model checked every cycle, plus directed literal expectations.
module tb_product_accumulator;

  localparam int MAX_TERMS = 256;
  localparam int CNT_W     = $clog2(MAX_TERMS + 1);

  logic              clk = 1'b0;
  logic              rst;
  logic              prod_valid;
  logic [31:0]       prod_data;
  logic              prod_last;
  logic              out_ready;

  logic              prod_ready, acc_valid, acc_ovf;
  logic [39:0]       acc_data;
  logic [CNT_W-1:0]  acc_count;

  logic              n_prod_ready, n_acc_valid, n_acc_ovf;
  logic [32:0]       n_acc_data;
  logic [CNT_W-1:0]  n_acc_count;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  product_accumulator #(.ACC_W(40), .MAX_TERMS(MAX_TERMS)) dut (
    .clk(clk), .rst(rst), .prod_valid(prod_valid), .prod_data(prod_data),
    .prod_last(prod_last), .prod_ready(prod_ready), .acc_valid(acc_valid),
    .acc_data(acc_data), .acc_count(acc_count), .acc_ovf(acc_ovf), .out_ready(out_ready)
  );

  product_accumulator #(.ACC_W(33), .MAX_TERMS(MAX_TERMS)) dut_narrow (
    .clk(clk), .rst(rst), .prod_valid(prod_valid), .prod_data(prod_data),
    .prod_last(prod_last), .prod_ready(n_prod_ready), .acc_valid(n_acc_valid),
    .acc_data(n_acc_data), .acc_count(n_acc_count), .acc_ovf(n_acc_ovf), .out_ready(out_ready)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Group-level model: the exact sum of the products in the open group, its term count,
  // and whether a finished result is waiting for the downstream handshake.
  logic [63:0] m_sum;
  int          m_cnt;
  bit          m_holding;
  bit          m_live = 1'b0;

  always @(negedge clk) begin
    if (m_live) begin
      check("prod_ready", prod_ready, !m_holding);
      check("acc_valid", acc_valid, m_holding);
      check("acc_data", acc_data, m_sum % (64'd1 << 40));
      check("acc_count", acc_count, m_cnt);
      check("acc_ovf", acc_ovf, m_sum >= (64'd1 << 40));
      check("n_prod_ready", n_prod_ready, !m_holding);
      check("n_acc_valid", n_acc_valid, m_holding);
      check("n_acc_data", n_acc_data, m_sum % (64'd1 << 33));
      check("n_acc_count", n_acc_count, m_cnt);
      check("n_acc_ovf", n_acc_ovf, m_sum >= (64'd1 << 33));
    end
    // Inputs are stable here until after the next rising edge, so this advances the model by that edge.
    if (rst) begin
      m_live    = 1'b1;
      m_sum     = 0;
      m_cnt     = 0;
      m_holding = 1'b0;
    end else if (m_live) begin
      if (m_holding) begin
        if (out_ready) begin
          m_holding = 1'b0;
          m_sum     = 0;
          m_cnt     = 0;
        end
      end else if (prod_valid) begin
        m_sum = m_sum + 64'(prod_data);
        m_cnt = m_cnt + 1;
        if (prod_last || m_cnt == MAX_TERMS) m_holding = 1'b1;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one product and returns just after the edge that accepted it.
  task automatic send(input logic [31:0] d, input logic l);
    logic rdy;
    int   waited;
    prod_valid = 1'b1;
    prod_data  = d;
    prod_last  = l;
    waited     = 0;
    forever begin
      @(negedge clk);
      rdy = prod_ready;
      step();
      if (rdy) break;
      waited++;
      if (waited > 50) begin
        check("send_timeout", 64'(waited), 64'd0);
        break;
      end
    end
    prod_valid = 1'b0;
    prod_last  = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    prod_valid = 1'b0;
    prod_data  = '0;
    prod_last  = 1'b0;
    out_ready  = 1'b0;
    step();
    step();
    rst = 1'b0;

    check("reset_data", acc_data, 64'd0);
    check("reset_ready", prod_ready, 64'd1);
    check("reset_valid", acc_valid, 64'd0);

    // Three-term group, downstream always ready.
    out_ready = 1'b1;
    send(32'd6, 1'b0);
    send(32'd20, 1'b0);
    send(32'd35, 1'b1);
    check("t1_valid", acc_valid, 64'd1);
    check("t1_data", acc_data, 64'd61);
    check("t1_count", acc_count, 64'd3);
    check("t1_ovf", acc_ovf, 64'd0);
    step();
    check("t1_valid_drop", acc_valid, 64'd0);
    check("t1_cleared", acc_data, 64'd0);

    // Single maximal product closed from IDLE.
    send(32'hFFFF_FFFF, 1'b1);
    check("t2_valid", acc_valid, 64'd1);
    check("t2_data", acc_data, 64'h00_FFFF_FFFF);
    check("t2_count", acc_count, 64'd1);
    step();

    // Forced completion at MAX_TERMS.
    out_ready = 1'b0;
    for (int i = 0; i < MAX_TERMS; i++) send(32'hFFFF_FFFF, 1'b0);
    check("t3_valid", acc_valid, 64'd1);
    check("t3_data", acc_data, 64'hFF_FFFF_FF00);
    check("t3_count", acc_count, 64'd256);
    check("t3_ovf", acc_ovf, 64'd0);
    check("t3_n_data", n_acc_data, 64'h1_FFFF_FF00);
    check("t3_n_ovf", n_acc_ovf, 64'd1);
    step();
    check("t3_ready_low", prod_ready, 64'd0);
    out_ready = 1'b1;
    step();

    // Wrap on the 33-bit accumulator.
    send(32'hFFFF_FFFF, 1'b0);
    send(32'hFFFF_FFFF, 1'b0);
    send(32'hFFFF_FFFF, 1'b1);
    check("t4_n_data", n_acc_data, 64'h0_FFFF_FFFD);
    check("t4_n_ovf", n_acc_ovf, 64'd1);
    check("t4_data", acc_data, 64'h2_FFFF_FFFD);
    check("t4_ovf", acc_ovf, 64'd0);
    step();

    // Backpressure on the result while a new product waits.
    out_ready = 1'b0;
    send(32'd7, 1'b1);
    prod_valid = 1'b1;
    prod_data  = 32'd9;
    prod_last  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("t5_ready", prod_ready, 64'd0);
      check("t5_valid", acc_valid, 64'd1);
      check("t5_data", acc_data, 64'd7);
      check("t5_count", acc_count, 64'd1);
    end
    out_ready = 1'b1;
    send(32'd9, 1'b1);
    check("t5_new_data", acc_data, 64'd9);
    check("t5_new_count", acc_count, 64'd1);
    step();

    // Reset in the middle of a group.
    out_ready = 1'b0;
    send(32'd5, 1'b0);
    send(32'd6, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t6_valid", acc_valid, 64'd0);
    check("t6_data", acc_data, 64'd0);
    check("t6_count", acc_count, 64'd0);
    check("t6_ready", prod_ready, 64'd1);
    send(32'd1, 1'b0);
    send(32'd2, 1'b1);
    check("t6_data_after", acc_data, 64'd3);
    check("t6_count_after", acc_count, 64'd2);
    out_ready = 1'b1;
    step();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
